pipe_shifter: RTL

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/pipe_shifter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipe_shifter.sv
// ----------------------------------------------------------------------------
// pipe_shifter
//
// Pipelined barrel shifter with valid/ready handshakes on both sides. The
// shifter runs on the operation as it is accepted. The result, carry-out and
// illegal-opcode flag then ride through a chain of STAGES elastic slots. The
// output is the last slot, so an unstalled operation appears STAGES cycles
// after acceptance. The chain sustains one operation per cycle.
//
// Parameters
//   WIDTH   operand/result width (power of two, 8..64)
//   AMT_W   shift-amount width (must exceed log2(WIDTH))
//   STAGES  number of pipeline slots (1..4)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, empties every slot
//   flush      synchronous; empties every slot at the next edge
//   in_valid   operation offered
//   in_ready   operation taken this cycle when high with in_valid
//   in_a       operand
//   in_op      000 LSL, 001 LSR, 010 ROR, 011 ASR, 100 RRX, others illegal
//   in_amt     unsigned shift amount
//   in_cin     carry in
//   out_valid  result offered
//   out_ready  result consumed this cycle when high with out_valid
//   out_res    result
//   out_cout   shifter carry out
//   out_err    illegal-opcode flag belonging to out_res
// ----------------------------------------------------------------------------
module pipe_shifter #(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_err
);

  localparam int LOGW = $clog2(WIDTH);

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b100;

  // Full shifter. The result is packed as {err, cout, res}.
  // LSL, LSR and ASR widen the operand by one bit on the side the bits leave.
  // The bit shifted into that extra position is the carry-out. A plain
  // shift of the widened value then covers every boundary case:
  //   - n = W leaves the edge bit as carry.
  //   - n > W leaves zero (LSL/LSR) or the sign (ASR).
  // ROR uses only n mod W. The left half of the rotate is shifted by
  // W - r, and that shift yields zero when r = 0.
  function automatic logic [WIDTH+1:0] shift_op(
    input logic [WIDTH-1:0] a,
    input logic [2:0]       op,
    input logic [AMT_W-1:0] amt,
    input logic             cin
  );
    logic [WIDTH-1:0]  res;
    logic              cout;
    logic              err;
    logic signed [WIDTH:0] sw;
    logic [LOGW-1:0]   rot;
    logic [LOGW:0]     lrot;
    res  = '0;
    cout = 1'b0;
    err  = 1'b0;
    sw   = $signed({a, 1'b0});
    rot  = amt[LOGW-1:0];
    lrot = (LOGW+1)'(WIDTH) - {1'b0, rot};
    case (op)
      OP_RRX: begin
        res  = {cin, a[WIDTH-1:1]};
        cout = a[0];
      end
      OP_LSL, OP_LSR, OP_ROR, OP_ASR: begin
        if (amt == '0) begin
          res  = a;
          cout = cin;
        end else begin
          case (op)
            OP_LSL:  {cout, res} = {1'b0, a} << amt;
            OP_LSR:  {res, cout} = {a, 1'b0} >> amt;
            OP_ASR:  {res, cout} = sw >>> amt;
            default: begin
              res  = (a >> rot) | (a << lrot);
              cout = res[WIDTH-1];
            end
          endcase
        end
      end
      default: err = 1'b1;
    endcase
    return {err, cout, res};
  endfunction

  logic [WIDTH+1:0] calc;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  res_q  [STAGES];
  logic              cout_q [STAGES];
  logic              err_q  [STAGES];
  logic              accept;

  assign calc = shift_op(in_a, in_op, in_amt, in_cin);

  // A slot moves forward when it holds something and there is room behind
  // it. Room exists if out_ready is high or any later slot is empty.
  // Scanning from the output end means each bit depends only on valids.
  always_comb begin
    logic hole;
    hole = out_ready;
    adv  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = vld[i] & hole;
      hole   = hole | ~vld[i];
    end
  end

  // During a flush the input is swallowed. It is therefore reported as
  // taken, but it never loads a slot.
  assign in_ready = flush | ~vld[0] | adv[0];
  assign accept   = in_valid & in_ready & ~flush;

  // Slot chain. Slot 0 loads a fresh result on acceptance. Each later slot
  // loads from its predecessor when the predecessor advances. A slot keeps
  // its contents while stalled, which holds the outputs stable under
  // backpressure. Flush and reset only clear the valids, but reset also
  // zeroes the data so the outputs read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i]  <= '0;
        cout_q[i] <= 1'b0;
        err_q[i]  <= 1'b0;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld[0] <= accept | (vld[0] & ~adv[0]);
      if (accept) begin
        res_q[0]  <= calc[WIDTH-1:0];
        cout_q[0] <= calc[WIDTH];
        err_q[0]  <= calc[WIDTH+1];
      end
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= adv[i-1] | (vld[i] & ~adv[i]);
        if (adv[i-1]) begin
          res_q[i]  <= res_q[i-1];
          cout_q[i] <= cout_q[i-1];
          err_q[i]  <= err_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_res   = res_q[STAGES-1];
  assign out_cout  = cout_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];

endmodule
